hazard_control_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 14 +
 rtl/mdu_tracker.sv | 63 ++++++
 rtl/hazard_control_unit.sv | 88 ++++++++
 tb/tb_hazard_control_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core control path: hazard FSM states and
// default multiply/divide unit occupancies.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hazard_state_e;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;
  localparam int MDU_CNT_W      = 6;

endpackage

// File: rtl/mdu_tracker.sv
// Tracks occupancy of the multi-cycle mult/div unit: a two-state FSM with a
// down-counter that reports busy and a one-cycle done pulse.
module mdu_tracker
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_done
);

  localparam logic [MDU_CNT_W-1:0] MUL_LOAD = MDU_CNT_W'(MUL_CYCLES - 1);
  localparam logic [MDU_CNT_W-1:0] DIV_LOAD = MDU_CNT_W'(DIV_CYCLES - 1);

  hazard_state_e          r_state;
  hazard_state_e          w_state_next;
  logic [MDU_CNT_W-1:0]   r_cnt;
  logic [MDU_CNT_W-1:0]   w_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A start seen while BUSY is ignored; the ID-stage stall makes it impossible.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = BUSY;
          w_cnt_next   = i_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == BUSY);
  assign o_done = (r_state == BUSY) && (r_cnt == '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use and MDU result stalls, taken-branch
// flushes, and a free-running count of stalled cycles.
module hazard_control_unit
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        uses_rs_id,
  input  logic        uses_rt_id,
  input  logic        hilo_read_id,
  input  logic        mdu_op_id,
  input  logic [4:0]  rt_ex,
  input  logic        mem_read_ex,
  input  logic        branch_taken_ex,
  input  logic        mdu_start_ex,
  input  logic        mdu_is_div_ex,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_count
);

  logic        w_load_use;
  logic        w_mdu_stall;
  logic        w_stall;
  logic [31:0] r_stall_count;

  mdu_tracker #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_tracker (
    .clk      (clk),
    .rst      (rst),
    .i_start  (mdu_start_ex),
    .i_is_div (mdu_is_div_ex),
    .o_busy   (mdu_busy),
    .o_done   (mdu_done)
  );

  // $zero is never a real producer, so a load into it cannot create a hazard.
  assign w_load_use = mem_read_ex && (rt_ex != 5'd0) &&
                      ((uses_rs_id && (rs_id == rt_ex)) ||
                       (uses_rt_id && (rt_id == rt_ex)));
  assign w_mdu_stall = (mdu_busy || mdu_start_ex) && (hilo_read_id || mdu_op_id);
  assign w_stall     = w_load_use || w_mdu_stall;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (branch_taken_ex) begin
      // ID holds a wrong-path instruction, so its stall request is moot.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (w_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (!pc_write) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit; a second instance with
// single-cycle multiply covers the minimum-latency case.
module tb_hazard_control_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        uses_rs_id;
  logic        uses_rt_id;
  logic        hilo_read_id;
  logic        mdu_op_id;
  logic [4:0]  rt_ex;
  logic        mem_read_ex;
  logic        branch_taken_ex;
  logic        mdu_start_ex;
  logic        mdu_is_div_ex;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mdu_busy;
  logic        mdu_done;
  logic [31:0] stall_count;

  logic        u1_pc_write;
  logic        u1_if_id_write;
  logic        u1_id_ex_bubble;
  logic        u1_if_id_flush;
  logic        u1_id_ex_flush;
  logic        u1_mdu_busy;
  logic        u1_mdu_done;
  logic [31:0] u1_stall_count;

  int vectors = 0;
  int errors  = 0;

  hazard_control_unit #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .hilo_read_id(hilo_read_id), .mdu_op_id(mdu_op_id),
    .rt_ex(rt_ex), .mem_read_ex(mem_read_ex),
    .branch_taken_ex(branch_taken_ex), .mdu_start_ex(mdu_start_ex),
    .mdu_is_div_ex(mdu_is_div_ex), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_count(stall_count)
  );

  hazard_control_unit #(.MUL_CYCLES(1), .DIV_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .hilo_read_id(hilo_read_id), .mdu_op_id(mdu_op_id),
    .rt_ex(rt_ex), .mem_read_ex(mem_read_ex),
    .branch_taken_ex(branch_taken_ex), .mdu_start_ex(mdu_start_ex),
    .mdu_is_div_ex(mdu_is_div_ex), .pc_write(u1_pc_write),
    .if_id_write(u1_if_id_write), .id_ex_bubble(u1_id_ex_bubble),
    .if_id_flush(u1_if_id_flush), .id_ex_flush(u1_id_ex_flush),
    .mdu_busy(u1_mdu_busy), .mdu_done(u1_mdu_done), .stall_count(u1_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_id = 5'd0; rt_id = 5'd0; uses_rs_id = 1'b0; uses_rt_id = 1'b0;
    hilo_read_id = 1'b0; mdu_op_id = 1'b0; rt_ex = 5'd0; mem_read_ex = 1'b0;
    branch_taken_ex = 1'b0; mdu_start_ex = 1'b0; mdu_is_div_ex = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    vectors++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush} !== 5'b00011) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00011",
               {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush});
    end
    vectors++;
    if ({mdu_busy, mdu_done, stall_count} !== 34'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b cnt=%0d exp all 0", mdu_busy, mdu_done, stall_count);
    end
    rst = 1'b0;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_load_use();
    mem_read_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8; uses_rs_id = 1'b1;
    #1;
    vectors++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush} !== 5'b00100) begin
      errors++;
      $display("FAIL load_use_rs got=%b exp=00100",
               {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush});
    end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (stall_count !== 32'd1 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL load_use_count cnt=%0d pc_write=%b exp cnt=1 pc_write=1", stall_count, pc_write);
    end
    // Load to $zero must never stall.
    mem_read_ex = 1'b1; rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    uses_rs_id = 1'b1; uses_rt_id = 1'b1;
    #1;
    vectors++;
    if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL load_use_r0 pc_write=%b bubble=%b exp 1/0", pc_write, id_ex_bubble);
    end
    // Match on rt only counts when the instruction actually reads rt.
    rt_ex = 5'd9; rs_id = 5'd3; rt_id = 5'd9; uses_rs_id = 1'b1; uses_rt_id = 1'b0;
    #1;
    vectors++;
    if (pc_write !== 1'b1) begin
      errors++;
      $display("FAIL load_use_rt_unused pc_write=%b exp=1", pc_write);
    end
    uses_rt_id = 1'b1;
    #1;
    vectors++;
    if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL load_use_rt pc_write=%b bubble=%b exp 0/1", pc_write, id_ex_bubble);
    end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (stall_count !== 32'd2) begin
      errors++;
      $display("FAIL load_use_count2 cnt=%0d exp=2", stall_count);
    end
    $display("test_load_use: done");
  endtask

  task automatic test_mult_mfhi();
    mdu_start_ex = 1'b1; mdu_is_div_ex = 1'b0; hilo_read_id = 1'b1;
    #1;
    vectors++;
    if (pc_write !== 1'b0 || mdu_busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_T pc_write=%b busy=%b exp 0/0", pc_write, mdu_busy);
    end
    tick();
    mdu_start_ex = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      vectors++;
      if (mdu_busy !== 1'b1 || pc_write !== 1'b0 || mdu_done !== (k == 4)) begin
        errors++;
        $display("FAIL mult_busy k=%0d busy=%b pc_write=%b done=%b exp 1/0/%b",
                 k, mdu_busy, pc_write, mdu_done, (k == 4));
      end
      tick();
    end
    #1;
    vectors++;
    if (mdu_busy !== 1'b0 || pc_write !== 1'b1 || stall_count !== 32'd7) begin
      errors++;
      $display("FAIL mult_release busy=%b pc_write=%b cnt=%0d exp 0/1/7", mdu_busy, pc_write, stall_count);
    end
    clear_inputs();
    $display("test_mult_mfhi: done");
  endtask

  task automatic test_div_independent();
    int busy_cycles = 0;
    int done_cycles = 0;
    mdu_start_ex = 1'b1; mdu_is_div_ex = 1'b1;
    #1;
    vectors++;
    if (pc_write !== 1'b1) begin
      errors++;
      $display("FAIL div_start pc_write=%b exp=1", pc_write);
    end
    tick();
    clear_inputs();
    for (int k = 0; k < 40; k++) begin
      #1;
      if (mdu_busy === 1'b1) busy_cycles++;
      if (mdu_done === 1'b1) done_cycles++;
      tick();
    end
    vectors++;
    if (busy_cycles != 32 || done_cycles != 1 || stall_count !== 32'd7) begin
      errors++;
      $display("FAIL div_indep busy=%0d done=%0d cnt=%0d exp 32/1/7", busy_cycles, done_cycles, stall_count);
    end
    $display("test_div_independent: done");
  endtask

  task automatic test_branch_load_use();
    mem_read_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8; uses_rs_id = 1'b1;
    branch_taken_ex = 1'b1;
    #1;
    vectors++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush} !== 5'b11011) begin
      errors++;
      $display("FAIL branch_load_use got=%b exp=11011",
               {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush});
    end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (stall_count !== 32'd7) begin
      errors++;
      $display("FAIL branch_count cnt=%0d exp=7", stall_count);
    end
    $display("test_branch_load_use: done");
  endtask

  task automatic test_reset_mid_div();
    mdu_start_ex = 1'b1; mdu_is_div_ex = 1'b1;
    tick();
    clear_inputs();
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (mdu_busy !== 1'b1 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_div busy=%b flush=%b%b pc_write=%b exp 1/11/0",
               mdu_busy, if_id_flush, id_ex_flush, pc_write);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (mdu_busy !== 1'b0 || mdu_done !== 1'b0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_after busy=%b done=%b cnt=%0d exp 0/0/0", mdu_busy, mdu_done, stall_count);
    end
    tick();
    $display("test_reset_mid_div: done");
  endtask

  task automatic test_mdu_in_id_while_busy();
    mdu_start_ex = 1'b1; mdu_is_div_ex = 1'b0; mdu_op_id = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      #1;
      vectors++;
      if (pc_write !== 1'b0) begin
        errors++;
        $display("FAIL mdu_id_stall k=%0d pc_write=%b exp=0", k, pc_write);
      end
      tick();
      mdu_start_ex = 1'b0;
    end
    #1;
    vectors++;
    if (pc_write !== 1'b1 || mdu_busy !== 1'b0 || stall_count !== 32'd5) begin
      errors++;
      $display("FAIL mdu_id_release pc_write=%b busy=%b cnt=%0d exp 1/0/5", pc_write, mdu_busy, stall_count);
    end
    tick();
    clear_inputs();
    mdu_start_ex = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      // A stray divide start mid-period must not reload the counter.
      mdu_start_ex = (k == 2); mdu_is_div_ex = (k == 2);
      #1;
      vectors++;
      if (mdu_busy !== 1'b1 || mdu_done !== (k == 4)) begin
        errors++;
        $display("FAIL mdu_second k=%0d busy=%b done=%b exp 1/%b", k, mdu_busy, mdu_done, (k == 4));
      end
      tick();
    end
    clear_inputs();
    #1;
    vectors++;
    if (mdu_busy !== 1'b0 || stall_count !== 32'd5) begin
      errors++;
      $display("FAIL mdu_second_end busy=%b cnt=%0d exp 0/5", mdu_busy, stall_count);
    end
    $display("test_mdu_in_id_while_busy: done");
  endtask

  task automatic test_latency_one();
    mdu_start_ex = 1'b1; mdu_is_div_ex = 1'b0;
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (u1_mdu_busy !== 1'b1 || u1_mdu_done !== 1'b1) begin
      errors++;
      $display("FAIL lat1_busy busy=%b done=%b exp 1/1", u1_mdu_busy, u1_mdu_done);
    end
    tick();
    vectors++;
    if (u1_mdu_busy !== 1'b0 || u1_mdu_done !== 1'b0) begin
      errors++;
      $display("FAIL lat1_end busy=%b done=%b exp 0/0", u1_mdu_busy, u1_mdu_done);
    end
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (mdu_busy !== 1'b0 || stall_count !== 32'd5) begin
      errors++;
      $display("FAIL lat1_main busy=%b cnt=%0d exp 0/5", mdu_busy, stall_count);
    end
    $display("test_latency_one: done");
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_mult_mfhi();
    test_div_independent();
    test_branch_load_use();
    test_reset_mid_div();
    test_mdu_in_id_while_busy();
    test_latency_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
